// File: rtl/instruction_decode_stage.sv
// MIPS-subset decode stage: combinational field/control decode feeding a small
// FIFO toward execute, with synchronous flush and a saturating illegal-opcode counter.
module instruction_decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            opcode,
    output logic [5:0]            funct,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shamt,
    output logic [25:0]           addr,
    output logic [DATA_WIDTH-1:0] imm_ext,
    output logic [4:0]            dest_reg,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  alu_src_imm,
    output logic                  branch_ne,
    output logic                  jump,
    output logic                  link,
    output logic                  illegal,
    output logic [7:0]            illegal_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic [5:0]            opcode;
        logic [5:0]            funct;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            rd;
        logic [4:0]            shamt;
        logic [25:0]           addr;
        logic [DATA_WIDTH-1:0] imm_ext;
        logic [4:0]            dest_reg;
        logic [PC_WIDTH-1:0]   pc;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  alu_src_imm;
        logic                  branch_ne;
        logic                  jump;
        logic                  link;
        logic                  illegal;
    } bundle_t;

    bundle_t               w_dec;
    bundle_t               w_head;
    logic [DATA_WIDTH-1:0] w_imm_sext;
    logic [DATA_WIDTH-1:0] w_imm_zext;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    bundle_t               r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [7:0]            r_illegal_count;

    assign w_imm_sext = DATA_WIDTH'($signed(instruction[15:0]));
    assign w_imm_zext = DATA_WIDTH'(instruction[15:0]);

    // Start from all-zero so fields a format does not use are always 0.
    always_comb begin
        w_dec        = '0;
        w_dec.opcode = instruction[31:26];
        w_dec.pc     = in_pc;
        case (instruction[31:26])
            OP_RTYPE: begin
                w_dec.rs        = instruction[25:21];
                w_dec.rt        = instruction[20:16];
                w_dec.rd        = instruction[15:11];
                w_dec.shamt     = instruction[10:6];
                w_dec.funct     = instruction[5:0];
                w_dec.dest_reg  = instruction[15:11];
                w_dec.reg_write = 1'b1;
            end
            OP_J: begin
                w_dec.addr = instruction[25:0];
                w_dec.jump = 1'b1;
            end
            OP_JAL: begin
                w_dec.addr      = instruction[25:0];
                w_dec.jump      = 1'b1;
                w_dec.link      = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.dest_reg  = 5'd31;
            end
            OP_ADDI, OP_LW, OP_XORI: begin
                w_dec.rs          = instruction[25:21];
                w_dec.rt          = instruction[20:16];
                w_dec.imm_ext     = (instruction[31:26] == OP_XORI) ? w_imm_zext : w_imm_sext;
                w_dec.reg_write   = 1'b1;
                w_dec.alu_src_imm = 1'b1;
                w_dec.mem_read    = (instruction[31:26] == OP_LW);
                w_dec.dest_reg    = instruction[20:16];
            end
            OP_SW: begin
                w_dec.rs          = instruction[25:21];
                w_dec.rt          = instruction[20:16];
                w_dec.imm_ext     = w_imm_sext;
                w_dec.mem_write   = 1'b1;
                w_dec.alu_src_imm = 1'b1;
            end
            OP_BNE: begin
                w_dec.rs        = instruction[25:21];
                w_dec.rt        = instruction[20:16];
                w_dec.imm_ext   = w_imm_sext;
                w_dec.branch_ne = 1'b1;
            end
            default: begin
                w_dec.rs      = instruction[25:21];
                w_dec.rt      = instruction[20:16];
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign out_valid = !w_empty;
    // Ready depends only on occupancy, never on out_ready, so a full FIFO refuses pushes.
    assign w_push   = in_valid && !w_full && !flush;
    assign w_pop    = !w_empty && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_illegal_count <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push && !w_pop)      r_count <= r_count + CW'(1);
                else if (w_pop && !w_push) r_count <= r_count - CW'(1);
            end
            if (w_push && w_dec.illegal && (r_illegal_count != 8'hFF))
                r_illegal_count <= r_illegal_count + 8'd1;
        end
    end

    // Storage needs no reset: contents are only visible while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
    end

    assign w_head = w_empty ? bundle_t'('0) : r_mem[r_rd_ptr];

    assign opcode        = w_head.opcode;
    assign funct         = w_head.funct;
    assign rs            = w_head.rs;
    assign rt            = w_head.rt;
    assign rd            = w_head.rd;
    assign shamt         = w_head.shamt;
    assign addr          = w_head.addr;
    assign imm_ext       = w_head.imm_ext;
    assign dest_reg      = w_head.dest_reg;
    assign pc            = w_head.pc;
    assign reg_write     = w_head.reg_write;
    assign mem_read      = w_head.mem_read;
    assign mem_write     = w_head.mem_write;
    assign alu_src_imm   = w_head.alu_src_imm;
    assign branch_ne     = w_head.branch_ne;
    assign jump          = w_head.jump;
    assign link          = w_head.link;
    assign illegal       = w_head.illegal;
    assign illegal_count = r_illegal_count;
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Bench for instruction_decode_stage: directed cases plus random traffic checked
// every cycle against a queue-based reference model of the decode stage.
module tb_instruction_decode_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instruction, in_pc, imm_ext, pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, dest_reg;
    logic [25:0] addr;
    logic        reg_write, mem_read, mem_write, alu_src_imm, branch_ne, jump, link, illegal;
    logic [7:0]  illegal_count;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs, rt, rd, shamt;
        logic [25:0] addr;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [7:0]  strobes; // reg_write,mem_read,mem_write,alu_src_imm,branch_ne,jump,link,illegal
    } exp_t;

    exp_t q[$];
    int   ill_cnt;
    int   n_checks = 0;
    int   n_err = 0;

    instruction_decode_stage #(.DATA_WIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .addr(addr),
        .imm_ext(imm_ext), .dest_reg(dest_reg), .pc(pc), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src_imm(alu_src_imm),
        .branch_ne(branch_ne), .jump(jump), .link(link), .illegal(illegal),
        .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode written directly from the instruction-set table.
    function automatic exp_t decode(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        logic [31:0] sext, zext;
        e = '0;
        sext = {{16{i[15]}}, i[15:0]};
        zext = {16'h0, i[15:0]};
        e.opcode = i[31:26];
        e.pc = p;
        case (i[31:26])
            6'd0:  begin e.rs = i[25:21]; e.rt = i[20:16]; e.rd = i[15:11]; e.shamt = i[10:6];
                         e.funct = i[5:0]; e.dest = i[15:11]; e.strobes = 8'b1000_0000; end
            6'd2:  begin e.addr = i[25:0]; e.strobes = 8'b0000_0100; end
            6'd3:  begin e.addr = i[25:0]; e.dest = 5'd31; e.strobes = 8'b1000_0110; end
            6'd8:  begin e.rs = i[25:21]; e.rt = i[20:16]; e.imm = sext; e.dest = i[20:16];
                         e.strobes = 8'b1001_0000; end
            6'd35: begin e.rs = i[25:21]; e.rt = i[20:16]; e.imm = sext; e.dest = i[20:16];
                         e.strobes = 8'b1101_0000; end
            6'd43: begin e.rs = i[25:21]; e.rt = i[20:16]; e.imm = sext; e.strobes = 8'b0011_0000; end
            6'd5:  begin e.rs = i[25:21]; e.rt = i[20:16]; e.imm = sext; e.strobes = 8'b0000_1000; end
            6'd14: begin e.rs = i[25:21]; e.rt = i[20:16]; e.imm = zext; e.dest = i[20:16];
                         e.strobes = 8'b1001_0000; end
            default: begin e.rs = i[25:21]; e.rt = i[20:16]; e.strobes = 8'b0000_0001; end
        endcase
        return e;
    endfunction

    task automatic model_step();
        bit   do_push, do_pop;
        exp_t d;
        do_push = in_valid && (q.size() < DEPTH) && !flush;
        do_pop  = (q.size() > 0) && out_ready && !flush;
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                d = decode(instruction, in_pc);
                q.push_back(d);
                if (d.strobes[0] && ill_cnt < 255) ill_cnt++;
                $display("push instr=%08h pc=%08h", instruction, in_pc);
            end
        end
    endtask

    task automatic check_all();
        exp_t e;
        e = (q.size() > 0) ? q[0] : exp_t'('0);
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("illegal_count", illegal_count, ill_cnt);
        chk("opcode", opcode, e.opcode);
        chk("funct", funct, e.funct);
        chk("rs/rt/rd/shamt", {rs, rt, rd, shamt}, {e.rs, e.rt, e.rd, e.shamt});
        chk("addr", addr, e.addr);
        chk("imm_ext", imm_ext, e.imm);
        chk("dest_reg", dest_reg, e.dest);
        chk("pc", pc, e.pc);
        chk("strobes", {reg_write, mem_read, mem_write, alu_src_imm, branch_ne, jump, link, illegal},
            e.strobes);
    endtask

    task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                         input logic ordy, input logic fl);
        in_valid = iv; instruction = ins; in_pc = p; out_ready = ordy; flush = fl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [5:0]  ops [9];
        logic [31:0] ins;
        ops = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd35, 6'd43, 6'd5, 6'd14, 6'd63};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instruction = '0; in_pc = '0; out_ready = 1'b0;
        ill_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
        chk("reset_in_ready", in_ready, 1'b1);

        // Directed decodes
        cycle(1'b1, 32'h2008FFFF, 32'h100, 1'b1, 1'b0);
        chk("addi_imm", imm_ext, 32'hFFFFFFFF);
        chk("addi_dest", dest_reg, 5'd8);
        chk("addi_rt", rt, 5'd8);
        cycle(1'b1, 32'h3929F0F0, 32'h104, 1'b1, 1'b0);
        chk("xori_imm", imm_ext, 32'h0000F0F0);
        chk("xori_dest", dest_reg, 5'd9);
        cycle(1'b1, 32'h00221820, 32'h108, 1'b1, 1'b0);
        chk("add_fields", {rs, rt, rd, funct}, {5'd1, 5'd2, 5'd3, 6'h20});
        chk("add_imm", imm_ext, 32'h0);
        cycle(1'b1, 32'h0C000010, 32'h10C, 1'b1, 1'b0);
        chk("jal_addr", addr, 26'h10);
        chk("jal_ctl", {jump, link, reg_write, dest_reg, rs, rt}, {3'b111, 5'd31, 10'd0});
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Fill, stall, full-with-out_ready, flush
        cycle(1'b1, 32'h8C450004, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'hAC450008, 32'h204, 1'b0, 1'b0);
        chk("full_ready", in_ready, 1'b0);
        cycle(1'b1, 32'h14A6FFFE, 32'h208, 1'b0, 1'b0);
        chk("stall_head_pc", pc, 32'h200);
        cycle(1'b1, 32'h14A6FFFE, 32'h208, 1'b1, 1'b0);
        chk("full_pop_head_pc", pc, 32'h204);
        cycle(1'b1, 32'h08000123, 32'h20C, 1'b0, 1'b0);
        cycle(1'b1, 32'h2008FFFF, 32'h210, 1'b0, 1'b1);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flushed_input_absent", out_valid, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 8)];
            if (ins[31:26] == 6'd63) ins[31:26] = 6'($urandom);
            cycle(($urandom_range(0, 3) != 0), ins, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0);
        end

        // Illegal saturation
        for (int n = 0; n < 260; n++) cycle(1'b1, 32'hFC000000, 32'h1000 + 32'(n), 1'b1, 1'b0);
        chk("ill_sat", illegal_count, 8'd255);
        chk("ill_strobe", illegal, 1'b1);

        // Asynchronous reset mid-stream
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        ill_cnt = 0;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_count", illegal_count, 8'd0);
        chk("async_rst_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Parametrised, buffered decode stage for the MIPS-subset datapath. It accepts raw 32-bit instructions with their PC over a valid/ready handshake and fully decodes every field. It generates the control bundle (sign- or zero-extended immediate, destination register, control strobes) and queues decoded bundles in a DEPTH-entry FIFO toward execute. It also supports a pipeline flush and counts illegal opcodes.

## Interface
- DATA_WIDTH, 32: width of extended immediate `imm_ext`; must be ≥16.
- PC_WIDTH, 32: width of `in_pc` / `pc`.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous; discards all queued bundles.
- in_valid  in  1  instruction present.
- in_ready  out  1  `!full`; push occurs on `in_valid & in_ready & !flush`.
- instruction  in  32  raw instruction word.
- in_pc  in  PC_WIDTH  PC of `instruction`.
- out_valid  out  1  `!empty`; head bundle valid.
- out_ready  in  1  consumer accepts head; pop on `out_valid & out_ready & !flush`.
- opcode/funct  out  6/6, rs/rt/rd/shamt  out  5 each, addr  out  26: head fields.
- imm_ext  out  DATA_WIDTH  extended immediate.
- dest_reg  out  5  write-back register.
- pc  out  PC_WIDTH  PC of head.
- reg_write, mem_read, mem_write, alu_src_imm, branch_ne, jump, link, illegal  out  1 each: control strobes.
- illegal_count  out  8  saturating count of illegal instructions accepted.

## Operation
- Decode is combinational on `instruction`; the bundle is written into the FIFO at push. All head outputs are driven from the FIFO head. When empty, every bundle output is 0.
- Every field is always defined. Fields unused by a format are 0. No field holds a value from a previous instruction.
- R-type (opcode 000000): rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0]; dest_reg=rd, reg_write=1.
- j (000010): addr=[25:0], jump=1.
- jal (000011): addr=[25:0], jump=1, link=1, reg_write=1, dest_reg=31.
- I-type: rs=[25:21], rt=[20:16].
  - addi (001000): imm_ext is sign-extended [15:0]; reg_write=1, alu_src_imm=1, dest_reg=rt.
  - lw (100011): imm_ext is sign-extended [15:0]; reg_write=1, mem_read=1, alu_src_imm=1, dest_reg=rt.
  - sw (101011): imm_ext is sign-extended [15:0]; mem_write=1, alu_src_imm=1, dest_reg=0.
  - bne (000101): imm_ext is sign-extended [15:0]; branch_ne=1, dest_reg=0.
  - xori (001110): imm_ext is zero-extended [15:0]; reg_write=1, alu_src_imm=1, dest_reg=rt.
- Any other opcode: illegal=1, all other strobes 0, opcode and rs/rt still decoded, bundle still queued. On push, illegal_count increments and saturates at 255.
- FIFO: wrapping read/write pointers of log2(DEPTH) bits plus an occupancy counter of 0..DEPTH.
- A simultaneous push and pop leaves occupancy unchanged; the pushed entry lands behind the popped one.
- flush sets occupancy to 0 and resets the pointers. Flush has priority over push and pop in the same cycle: that cycle's input is dropped and nothing is popped. illegal_count is unaffected by flush.

## Timing
- Reset (async assert, release synced by the system): occupancy=0, pointers=0, illegal_count=0. Hence out_valid=0, in_ready=1, all bundle outputs 0.
- Latency: an instruction pushed at edge N appears on the outputs with out_valid=1 after edge N when the FIFO was empty.
- Throughput: one instruction per cycle when out_ready=1 continuously.
- Full: in_ready=0. A push is impossible, even when out_ready=1 in the same cycle (no combinational ready path from out to in).
- The head bundle is stable while `out_valid & !out_ready`.
- Reset asserted mid-stream discards all entries immediately.

## Test plan
- Push 0x2008FFFF (addi $8,$0,-1) → next cycle: opcode=08, rt=8, imm_ext=0xFFFFFFFF, reg_write=1, alu_src_imm=1, dest_reg=8.
- Push 0x3929F0F0 (xori) → imm_ext=0x0000F0F0 (zero-extended), dest_reg=9. Then push 0x00221820 (add $3,$1,$2) → rs=1, rt=2, rd=3, funct=0x20, imm_ext=0, dest_reg=3.
- Push 0x0C000010 (jal) → addr=0x0000010, jump=1, link=1, reg_write=1, dest_reg=31, rs=rt=0.
- DEPTH=2, out_ready=0: push two instructions → in_ready=0, head unchanged. Assert flush with in_valid=1 → out_valid=0, in_ready=1 next cycle, flushed-cycle input absent.
- Push 0xFC000000 repeatedly, 260 times → illegal=1 on every bundle, illegal_count stops at 255. Assert rst_n=0 mid-stream → illegal_count=0 and out_valid=0 without waiting for a clock edge.
